// File: rtl/alu_pkg.sv
// Shared ALU definitions for alu_arbiter and its ALU: opcode encoding, default widths,
// arbiter state encoding and the legal-opcode check.
package alu_pkg;

    localparam int DATA_WIDTH_DEFAULT    = 32;
    localparam int OPCODE_LENGTH_DEFAULT = 4;
    localparam int SHAMT_WIDTH           = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLT = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_EQ  = 4'b1000,
        ALU_NE  = 4'b1001,
        ALU_LTU = 4'b1010,
        ALU_GEU = 4'b1011,
        ALU_SLL = 4'b1101,
        ALU_SRL = 4'b1110,
        ALU_SRA = 4'b1111
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // The three codes left unused by the 4-bit encoding are the only illegal ones.
    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            4'b0011, 4'b0111, 4'b1100: return 1'b0;
            default:                   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the two alu_arbiter requesters.
// Illegal opcodes (including any set bit above bit 3) give a zero result and err=1.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int OPCODE_LENGTH = OPCODE_LENGTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] op,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     err
);

    logic [3:0]             op_code;
    logic                   upper_clear;
    logic [SHAMT_WIDTH-1:0] shamt;

    assign op_code = op[3:0];
    assign shamt   = srcb[SHAMT_WIDTH-1:0];

    if (OPCODE_LENGTH > 4) begin : g_wide_op
        assign upper_clear = ~|op[OPCODE_LENGTH-1:4];
    end else begin : g_narrow_op
        assign upper_clear = 1'b1;
    end

    always_comb begin
        result = '0;
        err    = 1'b0;
        if (!upper_clear || !is_legal_op(op_code)) begin
            err = 1'b1;
        end else begin
            case (alu_op_e'(op_code))
                ALU_AND: result = srca & srcb;
                ALU_OR:  result = srca | srcb;
                ALU_ADD: result = srca + srcb;
                ALU_SLT: result = DATA_WIDTH'($signed(srca) < $signed(srcb));
                ALU_XOR: result = srca ^ srcb;
                ALU_SUB: result = srca - srcb;
                ALU_EQ:  result = DATA_WIDTH'(srca == srcb);
                ALU_NE:  result = DATA_WIDTH'(srca != srcb);
                ALU_LTU: result = DATA_WIDTH'(srca < srcb);
                ALU_GEU: result = DATA_WIDTH'(srca >= srcb);
                ALU_SLL: result = srca << shamt;
                ALU_SRL: result = srca >> shamt;
                ALU_SRA: result = $unsigned($signed(srca) >>> shamt);
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one ALU with a single registered result slot.
// Define ALU_ARBITER_RR_EN for round-robin contention; default is fixed priority to requester 0.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int OPCODE_LENGTH = OPCODE_LENGTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic                     rsp_err
);

    arb_state_e state;
    arb_state_e state_next;

    logic                     contention_grant;
    logic                     grant;
    logic                     can_accept;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic                     alu_err;

`ifdef ALU_ARBITER_RR_EN
    logic last_grant;

    // Reset value 1 makes requester 0 the winner of the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    assign contention_grant = ~last_grant;
`else
    assign contention_grant = 1'b0;
`endif

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = contention_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // The slot can take a new operation when empty or when its current result leaves this cycle.
    assign can_accept = !reset && ((state == ST_EMPTY) || rsp_ready);
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign alu_srca = grant ? req1_srca : req0_srca;
    assign alu_srcb = grant ? req1_srcb : req0_srcb;
    assign alu_op   = grant ? req1_op   : req0_op;

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .srca   (alu_srca),
        .srcb   (alu_srcb),
        .op     (alu_op),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rsp_valid  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                rsp_valid = 1'b1;
                if (rsp_ready && !accept) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Payload only moves on accept, so it stays put while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            rsp_id     <= grant;
            rsp_result <= alu_result;
            rsp_err    <= alu_err;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; expectations follow ALU_ARBITER_RR_EN
// when it is defined, otherwise fixed priority.
module tb_alu_arbiter;

    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;

`ifdef ALU_ARBITER_RR_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_srca  (req0_srca),
        .req0_srcb  (req0_srcb),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_srca  (req1_srca),
        .req1_srcb  (req1_srcb),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy,
                                 input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
        reset      = rst;
        rsp_ready  = rdy;
        req0_valid = v0;
        req0_op    = op0;
        req0_srca  = a0;
        req0_srcb  = b0;
        req1_valid = v1;
        req1_op    = op1;
        req1_srca  = a1;
        req1_srcb  = b1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic id, input logic [31:0] res, input logic err);
        checkOutput({tag, ".valid"},  32'(rsp_valid),  32'(v));
        checkOutput({tag, ".id"},     32'(rsp_id),     32'(id));
        checkOutput({tag, ".result"}, rsp_result,      res);
        checkOutput({tag, ".err"},    32'(rsp_err),    32'(err));
    endtask

    logic [3:0]  op_list  [9] = '{4'b0111, 4'b1111, 4'b0100, 4'b1010, 4'b1101,
                                  4'b1000, 4'b1110, 4'b1011, 4'b1100};
    logic [31:0] a_list   [9] = '{32'h5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
                                  32'h5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b_list   [9] = '{32'h3, 32'h4, 32'h1, 32'h1, 32'd31,
                                  32'h5, 32'h4, 32'h1, 32'h1};
    logic [31:0] res_list [9] = '{32'h0, 32'hF8000000, 32'h1, 32'h0, 32'h80000000,
                                  32'h1, 32'h08000000, 32'h1, 32'h0};
    logic        err_list [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic        exp_id;
        logic [31:0] exp_res;

        // Reset with requester 0 pushing: nothing may be accepted.
        applyStimulus(1'b1, 1'b1, 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, OP_OR, 32'd0, 32'd0);
        checkOutput("reset.req0_ready", 32'(req0_ready), 32'd0);
        tick();
        tick();
        checkRsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);

        // Single ADD with one-cycle latency, then drain.
        applyStimulus(1'b0, 1'b1, 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, OP_OR, 32'd0, 32'd0);
        checkOutput("add.req0_ready", 32'(req0_ready), 32'd1);
        tick();
        checkRsp("add", 1'b1, 1'b0, 32'd12, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_OR, 32'd0, 32'd0);
        tick();
        checkOutput("drain.valid", 32'(rsp_valid), 32'd0);

        // Fresh reset so the contention sequence starts from the reset grant history.
        applyStimulus(1'b1, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_OR, 32'd0, 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            exp_id  = ROUND_ROBIN ? k[0] : 1'b0;
            exp_res = exp_id ? 32'hFF : 32'd7;
            applyStimulus(1'b0, 1'b1, 1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'h0F);
            checkOutput($sformatf("cont%0d.req0_ready", k), 32'(req0_ready), 32'(!exp_id));
            checkOutput($sformatf("cont%0d.req1_ready", k), 32'(req1_ready), 32'(exp_id));
            tick();
            checkRsp($sformatf("cont%0d", k), 1'b1, exp_id, exp_res, 1'b0);
        end

        // Consumer stalls while requester 1 waits: held result must not move.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, OP_SUB, 32'd0, 32'd0, 1'b1, OP_XOR, 32'hF0, 32'h0F);
            checkOutput($sformatf("stall%0d.req1_ready", k), 32'(req1_ready), 32'd0);
            tick();
            checkRsp($sformatf("stall%0d", k), 1'b1, 1'b0, 32'd7, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, OP_SUB, 32'd0, 32'd0, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        checkOutput("unstall.req1_ready", 32'(req1_ready), 32'd1);
        tick();
        checkRsp("unstall", 1'b1, 1'b1, 32'hFF, 1'b0);

        // Back-to-back opcode table on requester 0, including illegal codes.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, op_list[k], a_list[k], b_list[k], 1'b0, OP_OR, 32'd0, 32'd0);
            checkOutput($sformatf("op%0d.req0_ready", k), 32'(req0_ready), 32'd1);
            tick();
            checkRsp($sformatf("op%b", op_list[k]), 1'b1, 1'b0, res_list[k], err_list[k]);
        end

        // Reset while FULL discards the result; the next contention goes to requester 0.
        applyStimulus(1'b1, 1'b1, 1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        checkOutput("rstfull.req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rstfull.req1_ready", 32'(req1_ready), 32'd0);
        tick();
        checkRsp("rstfull", 1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        checkOutput("postrst.req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("postrst.req1_ready", 32'(req1_ready), 32'd0);
        tick();
        checkRsp("postrst", 1'b1, 1'b0, 32'd7, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, OP_SUB, 32'd0, 32'd0, 1'b0, OP_XOR, 32'd0, 32'd0);
        tick();
        checkOutput("final.valid", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4, ALU operation-code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester i's operation is accepted this cycle.
REQ-007 SHALL have ports req0_srca, req0_srcb, req1_srca, req1_srcb  input  DATA_WIDTH  operands.
REQ-008 SHALL have ports req0_op / req1_op  input  OPCODE_LENGTH  ALU operation code.
REQ-009 SHALL have port rsp_valid  output  1  registered result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port rsp_id  output  1  requester index owning the result.
REQ-012 SHALL have port rsp_result  output  DATA_WIDTH  ALU result.
REQ-013 SHALL have port rsp_err  output  1  accepted opcode was not a legal ALU code.

Function
REQ-014 SHALL share one ALU between two requesters; a transfer occurs when reqi_valid and reqi_ready are both high at a rising edge.
REQ-015 SHALL implement states EMPTY (rsp_valid=0) and FULL (rsp_valid=1): EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept (back-to-back).
REQ-016 SHALL assert at most one reqi_ready per cycle, only for the granted requester, and only when state is EMPTY or rsp_ready is high.
REQ-017 SHALL give a fixed latency of one cycle: operation accepted at edge N appears on rsp_* from edge N to the edge where rsp_valid and rsp_ready are both high.
REQ-018 SHALL hold rsp_result, rsp_id and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-019 SHALL compute results per ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0100 signed SLT, 0101 XOR, 0110 SUB, 1000 EQ, 1001 NE, 1010 unsigned LT, 1011 unsigned GE, 1101 SLL, 1110 SRL, 1111 SRA (shift amount srcb[4:0]); comparisons yield 1 or 0.
REQ-020 SHALL, for codes 0011, 0111, 1100, produce rsp_result=0 and rsp_err=1; rsp_err=0 otherwise.
REQ-021 SHALL grant a lone valid requester immediately, regardless of arbitration history.
REQ-022 SHALL update last_grant only on an accepted transfer.
REQ-023 reqi_ready SHALL depend combinationally on both reqi_valid and rsp_ready; requesters shall not make valid depend on ready.
REQ-024 SHALL ignore operand/opcode inputs of a non-accepted requester; a requester holds valid and payload until accepted.

Reset
REQ-025 On reset high at an edge SHALL set state EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, last_grant=1 (requester 0 wins next contention).
REQ-026 Reset asserted while FULL SHALL discard the held result; no accept occurs in a reset cycle and reqi_ready SHALL be 0 while reset is high.

Configuration
REQ-027 With macro ALU_ARBITER_RR_EN defined, contention (both valid) SHALL grant the requester not in last_grant (round-robin).
REQ-028 Without ALU_ARBITER_RR_EN, contention SHALL always grant requester 0 (fixed priority); last_grant register SHALL be omitted.

Structure
REQ-029 A shared package alu_pkg SHALL hold the ALU opcode enum/constants, DATA_WIDTH/OPCODE_LENGTH defaults and an is_legal_op function.
REQ-030 SHALL instantiate the existing combinational ALU as the sole sub-module (alu); arbitration, operand mux and output register live in alu_arbiter.

Verification
REQ-031 Reset then req0 ADD 5+7, rsp_ready=1 -> req0_ready=1, next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_err=0.
REQ-032 Both valid every cycle (req0 SUB 10-3, req1 XOR F0^0F), rsp_ready=1, RR enabled -> results 7 (id0), FF (id1), 7 (id0) alternating; RR disabled -> only id0 served, req1_ready stays 0.
REQ-033 FULL with rsp_ready=0 for 3 cycles, req1 valid -> req1_ready=0, rsp_* stable; rsp_ready=1 -> req1 accepted same cycle, next result follows with no gap.
REQ-034 req0 op 0111 -> rsp_result=0, rsp_err=1; req0 SRA 80000000>>>4 -> F8000000; SLT FFFFFFFF,1 -> 1; BLT-code 1010 FFFFFFFF,1 -> 0.
REQ-035 Reset asserted while FULL -> next cycle rsp_valid=0; first contention after reset grants requester 0.
